// File: rtl/sqrt_error_monitor_pkg.sv
// rtl/sqrt_error_monitor_pkg.sv - shared widths, FSM states and saturating add
package sqrt_err_pkg;

  localparam int IN_W  = 16;
  localparam int OUT_W = IN_W / 2;
  localparam int CNT_W = 17;
  localparam int SUM_W = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // a + b clamped to the all-ones value of a w-bit field (w <= 32)
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/sqrt_error_monitor_if.sv
// rtl/sqrt_error_monitor_if.sv - sample handshake and per-sample result bundle
interface sqrt_error_monitor_if
  import sqrt_err_pkg::*;
#(
  parameter int IN_W  = sqrt_err_pkg::IN_W,
  parameter int OUT_W = IN_W / 2
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_r;
  logic [OUT_W-1:0] in_q;
  logic             res_valid;
  logic [OUT_W-1:0] res_ref;
  logic [OUT_W-1:0] res_ed;
  logic             res_mismatch;

  // master: the approximate root unit feeding samples and watching results
  modport master (
    output in_valid, in_r, in_q,
    input  in_ready, res_valid, res_ref, res_ed, res_mismatch
  );

  // slave: the error monitor
  modport slave (
    input  in_valid, in_r, in_q,
    output in_ready, res_valid, res_ref, res_ed, res_mismatch
  );

endinterface

// File: rtl/isqrt_seq.sv
// rtl/isqrt_seq.sv - restoring integer square root, one root bit per cycle MSB first
module isqrt_seq
  import sqrt_err_pkg::*;
#(
  parameter int IN_W  = sqrt_err_pkg::IN_W,
  parameter int OUT_W = IN_W / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IN_W-1:0]  radicand,
  output logic             done,
  output logic [OUT_W-1:0] root
);

  localparam int CW = $clog2(OUT_W + 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [IN_W-1:0]  rad_sh;
  logic [OUT_W+1:0] rem;
  logic [OUT_W+1:0] rem_sh;
  logic [OUT_W+1:0] trial;
  logic [OUT_W+1:0] diff;
  logic             take;

  // next radicand digit pair enters the remainder; trial divisor is 4*root+1
  always_comb begin
    rem_sh = (rem << 2) | {{OUT_W{1'b0}}, rad_sh[IN_W-1 -: 2]};
    trial  = {root, 2'b01};
    diff   = rem_sh - trial;
    take   = (rem_sh >= trial);
  end

  // done marks the cycle whose closing edge produces the last root bit
  assign done = busy && (cnt == '0);

  // iteration state: load on start, one bit per edge, abort returns to rest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      rad_sh <= '0;
      rem    <= '0;
      root   <= '0;
    end else if (abort) begin
      busy   <= 1'b0;
      cnt    <= '0;
      rad_sh <= '0;
      rem    <= '0;
      root   <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(OUT_W - 1);
      rad_sh <= radicand;
      rem    <= '0;
      root   <= '0;
    end else if (busy) begin
      rem    <= take ? diff : rem_sh;
      root   <= {root[OUT_W-2:0], take};
      rad_sh <= rad_sh << 2;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/sqrt_error_monitor.sv
// rtl/sqrt_error_monitor.sv - per-sample error distance and running error totals
module sqrt_error_monitor #(
  parameter int IN_W  = sqrt_err_pkg::IN_W,
  parameter int OUT_W = IN_W / 2,
  parameter int CNT_W = sqrt_err_pkg::CNT_W,
  parameter int SUM_W = sqrt_err_pkg::SUM_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  sqrt_error_monitor_if.slave  bus,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [SUM_W-1:0]     ed_sum,
  output logic [OUT_W-1:0]     ed_max
);

  import sqrt_err_pkg::*;

  state_t           state;
  logic [OUT_W-1:0] q_lat;
  logic             accept;
  logic             eng_done;
  logic [OUT_W-1:0] eng_root;
  logic [OUT_W-1:0] ed;
  logic             mismatch;

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && (state == IDLE) && !clear;

  // the engine latches the radicand itself on accept
  isqrt_seq #(.IN_W(IN_W), .OUT_W(OUT_W)) u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept),
    .abort    (clear),
    .radicand (bus.in_r),
    .done     (eng_done),
    .root     (eng_root)
  );

  // error distance between the exact root and the latched approximation
  always_comb begin
    ed       = (eng_root > q_lat) ? (eng_root - q_lat) : (q_lat - eng_root);
    mismatch = (eng_root != q_lat);
  end

  // control FSM, result registers and saturating accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      q_lat            <= '0;
      bus.res_valid    <= 1'b0;
      bus.res_ref      <= '0;
      bus.res_ed       <= '0;
      bus.res_mismatch <= 1'b0;
      sample_count     <= '0;
      err_count        <= '0;
      ed_sum           <= '0;
      ed_max           <= '0;
    end else if (clear) begin
      state            <= IDLE;
      q_lat            <= '0;
      bus.res_valid    <= 1'b0;
      bus.res_ref      <= '0;
      bus.res_ed       <= '0;
      bus.res_mismatch <= 1'b0;
      sample_count     <= '0;
      err_count        <= '0;
      ed_sum           <= '0;
      ed_max           <= '0;
    end else begin
      bus.res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            q_lat <= bus.in_q;
            state <= CALC;
          end
        end
        CALC: begin
          if (eng_done) state <= UPDATE;
        end
        UPDATE: begin
          bus.res_valid    <= 1'b1;
          bus.res_ref      <= eng_root;
          bus.res_ed       <= ed;
          bus.res_mismatch <= mismatch;
          sample_count     <= CNT_W'(sat_add(32'(sample_count), 32'd1, CNT_W));
          err_count        <= CNT_W'(sat_add(32'(err_count), 32'(mismatch), CNT_W));
          ed_sum           <= SUM_W'(sat_add(32'(ed_sum), 32'(ed), SUM_W));
          if (ed > ed_max) ed_max <= ed;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sqrt_error_monitor.md
# sqrt_error_monitor

Synthesizable error-metric accumulator for the approximate square-root datapath. It sits on the output side of an approximate square-root unit and consumes (radicand, approximate root) pairs through a valid/ready handshake. For each pair it computes the exact integer square root with a sequential digit-by-digit engine and reports the per-sample error distance. It also maintains running totals (sample count, mismatch count, ED sum, ED max) so that ER, NMED and EDmax can be derived on-chip or read out after a sweep.

## Interface
- IN_W, 16, radicand width; must be even
- OUT_W, IN_W/2, root width
- CNT_W, 17, width of sample_count and err_count; holds 65536
- SUM_W, 24, width of ed_sum
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous clear of accumulators; aborts any in-flight sample
- in_valid  in  1  sample present
- in_ready  out  1  block can accept; high only in IDLE
- in_r  in  IN_W  radicand R
- in_q  in  OUT_W  approximate root Q under test
- res_valid  out  1  one-cycle pulse, per-sample result valid
- res_ref  out  OUT_W  exact floor(sqrt(R))
- res_ed  out  OUT_W  |ref - Q|
- res_mismatch  out  1  ref != Q
- sample_count  out  CNT_W  accepted and completed samples
- err_count  out  CNT_W  completed samples with mismatch
- ed_sum  out  SUM_W  sum of res_ed
- ed_max  out  OUT_W  maximum res_ed

## Operation
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- FSM states:
  - IDLE: in_ready=1.
  - CALC: OUT_W iterations.
  - UPDATE: accumulate, then return to IDLE.
- Accept when in_valid && in_ready && !clear. in_r and in_q are latched and the FSM moves to CALC. Inputs may change after the accept edge.
- CALC uses a restoring square root, one result bit per cycle, MSB first:
  - Remainder width OUT_W+2. Trial value = {root, 2'b01}.
  - If remainder_shifted >= trial: subtract and set the root bit to 1; otherwise restore and set the root bit to 0.
  - The iteration counter runs OUT_W-1 down to 0, then the FSM enters UPDATE.
- UPDATE, performed in a single edge:
  - ed = (ref > Q) ? ref-Q : Q-ref.
  - Register res_ref, res_ed and res_mismatch; pulse res_valid.
  - sample_count += 1; err_count += mismatch; ed_sum += ed; ed_max = max(ed_max, ed).
- All counters saturate at all-ones and never wrap.
- clear (synchronous):
  - Zeroes all accumulators and res_* outputs.
  - Forces the FSM to IDLE; an in-flight sample is discarded with no res_valid.
  - Takes priority over accept and over UPDATE in the same cycle.
- Reset mid-operation behaves like clear, but is asynchronous.
- Reset values: in_ready=1 (IDLE), res_valid=0, all other outputs 0.

## Timing
- The accept edge is cycle 0. CALC occupies edges 1..OUT_W (8 for default widths). The UPDATE edge is OUT_W+1.
- res_valid is high for exactly one cycle after edge OUT_W+1. Accumulators show the new values in that same cycle.
- in_ready drops after the accept edge and is high again in the cycle res_valid is high. A new sample may be accepted on the following edge.
- Minimum sample period is OUT_W+2 cycles (10 for defaults).
- in_valid held while in_ready=0 is ignored, not queued.
- res_* outputs hold their last values until the next UPDATE or clear.

## Structure
- Package sqrt_err_pkg holds:
  - Default width constants: IN_W, OUT_W, CNT_W, SUM_W.
  - The state enum: IDLE, CALC, UPDATE.
  - A saturating-add helper function.
- Sub-module isqrt_seq holds the restoring root engine:
  - Ports: start, radicand, done, root.
  - It is iterated by a counter and is restartable via an abort input driven by clear.
- The top module contains the FSM, the input latch, ED logic and the accumulators.

## Test plan
- Reset, then R=0, Q=0: after 10 cycles res_ref=0, res_ed=0, res_mismatch=0, sample_count=1, err_count=0.
- R=65535, Q=255 followed by R=15, Q=4:
  - First sample: ref 255, match.
  - Second sample: ref 3, ed 1, mismatch. err_count=1, ed_sum=1, ed_max=1.
- R=100, Q=7, then R=99, Q=9:
  - First sample: ref 10, ed 3.
  - Second sample: ref 9, ed 0.
  - ed_max stays 3, ed_sum=3.
- Backpressure: hold in_valid high with changing data for 25 cycles. Exactly 3 samples are accepted (cycles 0, 10, 20), in_ready=0 between accepts, and the results match the data present on the accept edges.
- clear asserted at cycle 4 of a CALC, and clear coincident with in_valid:
  - No res_valid occurs; all accumulators read 0; in_ready=1 the next cycle; no accept happens on the clear edge.
  - Asynchronous rst_n pulse mid-CALC gives the same result.
- Full sweep R=0..65535 with Q from a behavioral approximate-root model:
  - Every res_ref equals $rtoi($sqrt(R)).
  - Final sample_count=65536, and err_count, ed_sum and ed_max equal the software totals.
